// File: rtl/reg_file_32.sv
// ============================================================================
// reg_file_32 : 32-entry register file, one-hot decoded write port,
//               two registered read ports with optional write bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_32 #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic [31:0]      wen0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [4:0]       raddr0,
  input  logic [4:0]       raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             err0,
  output logic [15:0]      wcnt0
);

  localparam int c_NREGS = 32;

  logic [WIDTH-1:0] regs_q [1:c_NREGS-1];
  logic [WIDTH-1:0] w_regs [c_NREGS];

  logic             w_onehot;
  logic             w_multi;
  logic             w_commit;
  logic [4:0]       w_idx;

  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic             err_q, err_d;
  logic [15:0]      wcnt_q, wcnt_d;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign w_onehot = (wen0 != 32'd0) && ((wen0 & (wen0 - 32'd1)) == 32'd0);
  assign w_multi  = we0 && (wen0 != 32'd0) && !w_onehot;
  assign w_commit = we0 && w_onehot && !wen0[0];

  always_comb begin
    w_idx = 5'd0;
    for (int i = 0; i < c_NREGS; i++) begin
      if (wen0[i]) w_idx = 5'(i);
    end
  end

  generate
    for (genvar gi = 1; gi < c_NREGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= '0;
        end else if (w_commit && wen0[gi]) begin
          regs_q[gi] <= wdata0;
        end
      end
    end
  endgenerate

  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < c_NREGS; i++) begin
      w_regs[i] = regs_q[i];
    end
  end

  always_comb begin
    rdata0_d = w_regs[raddr0];
    rdata1_d = w_regs[raddr1];
    if (BYPASS && w_commit && (w_idx == raddr0)) rdata0_d = wdata0;
    if (BYPASS && w_commit && (w_idx == raddr1)) rdata1_d = wdata0;
    // Bypass can never hit address 0 because a commit excludes index 0.
    err_d  = err_q | w_multi;
    wcnt_d = w_commit ? (wcnt_q + 16'd1) : wcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= 16'd0;
    end else begin
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign err0   = err_q;
  assign wcnt0  = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_32.sv
// ============================================================================
// tb_reg_file_32 : directed self-checking bench, BYPASS=1 and BYPASS=0 copies.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0;
  logic [31:0] wen0;
  logic [31:0] wdata0;
  logic [4:0]  raddr0;
  logic [4:0]  raddr1;

  logic [31:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic        err0_a, err0_b;
  logic [15:0] wcnt0_a, wcnt0_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_32 #(.WIDTH(32), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .rst(rst), .we0(we0), .wen0(wen0), .wdata0(wdata0),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0_a), .rdata1(rdata1_a),
    .err0(err0_a), .wcnt0(wcnt0_a)
  );

  reg_file_32 #(.WIDTH(32), .BYPASS(1'b0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .we0(we0), .wen0(wen0), .wdata0(wdata0),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .err0(err0_b), .wcnt0(wcnt0_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we0 = 1'b0; wen0 = '0; wdata0 = '0; raddr0 = '0; raddr1 = '0;
    tick();
    tick();
    check("rst_rdata0", rdata0_a, 32'd0);
    check("rst_err0",   {31'd0, err0_a}, 32'd0);
    check("rst_wcnt0",  {16'd0, wcnt0_a}, 32'd0);
    rst = 1'b0;

    for (int a = 1; a < 32; a++) begin
      raddr0 = 5'(a);
      raddr1 = 5'(a);
      tick();
      check($sformatf("init_rd0_r%0d", a), rdata0_a, 32'd0);
      check($sformatf("init_rd1_r%0d", a), rdata1_a, 32'd0);
    end
    check("init_err0",  {31'd0, err0_a}, 32'd0);
    check("init_wcnt0", {16'd0, wcnt0_a}, 32'd0);

    // plain write to r5, read back a cycle later
    raddr0 = 5'd0; raddr1 = 5'd0;
    we0 = 1'b1; wen0 = 32'h0000_0020; wdata0 = 32'hDEAD_BEEF;
    tick();
    we0 = 1'b0; wen0 = '0; raddr0 = 5'd5;
    tick();
    check("wr_r5_rd0", rdata0_a, 32'hDEAD_BEEF);
    check("wr_r5_wcnt", {16'd0, wcnt0_a}, 32'd1);

    // bypass on port 1, both variants
    we0 = 1'b1; wen0 = 32'd1 << 7; wdata0 = 32'h1234_5678; raddr1 = 5'd7;
    tick();
    check("byp1_on",  rdata1_a, 32'h1234_5678);
    check("byp1_off", rdata1_b, 32'd0);
    check("byp_wcnt", {16'd0, wcnt0_a}, 32'd2);
    we0 = 1'b0; wen0 = '0;
    tick();
    check("byp1_off_after", rdata1_b, 32'h1234_5678);

    // bypass on port 0, both variants
    we0 = 1'b1; wen0 = 32'd1 << 12; wdata0 = 32'h0BAD_F00D; raddr0 = 5'd12;
    tick();
    check("byp0_on",  rdata0_a, 32'h0BAD_F00D);
    check("byp0_off", rdata0_b, 32'd0);

    // both ports on the same address
    we0 = 1'b0; wen0 = '0; raddr0 = 5'd5; raddr1 = 5'd5;
    tick();
    check("same_rd0", rdata0_a, 32'hDEAD_BEEF);
    check("same_rd1", rdata1_a, 32'hDEAD_BEEF);

    // write to r0 is a no-op
    we0 = 1'b1; wen0 = 32'h1; wdata0 = 32'hFFFF_FFFF; raddr0 = 5'd0; raddr1 = 5'd0;
    tick();
    check("r0_byp_rd0", rdata0_a, 32'd0);
    we0 = 1'b0; wen0 = '0;
    tick();
    check("r0_rd0",  rdata0_a, 32'd0);
    check("r0_wcnt", {16'd0, wcnt0_a}, 32'd3);
    check("r0_err",  {31'd0, err0_a}, 32'd0);

    // we0 with no enable, and multi-hot with we0 low
    we0 = 1'b1; wen0 = 32'h0;
    tick();
    we0 = 1'b0; wen0 = 32'h0000_0006; wdata0 = 32'h5555_5555;
    tick();
    check("nowr_wcnt", {16'd0, wcnt0_a}, 32'd3);
    check("nowr_err",  {31'd0, err0_a}, 32'd0);

    // multi-hot write: flagged, nothing written
    we0 = 1'b1; wen0 = 32'h0000_0006; wdata0 = 32'hAAAA_AAAA; raddr0 = 5'd1; raddr1 = 5'd2;
    tick();
    check("multi_err",  {31'd0, err0_a}, 32'd1);
    check("multi_wcnt", {16'd0, wcnt0_a}, 32'd3);
    check("multi_byp1", rdata0_a, 32'd0);
    we0 = 1'b1; wen0 = 32'd1 << 9; wdata0 = 32'h0000_0077;
    tick();
    check("multi_r1", rdata0_a, 32'd0);
    check("multi_r2", rdata1_a, 32'd0);
    check("sticky_err",  {31'd0, err0_a}, 32'd1);
    check("sticky_wcnt", {16'd0, wcnt0_a}, 32'd4);
    we0 = 1'b0; wen0 = '0; raddr0 = 5'd9;
    tick();
    check("r9_rd0", rdata0_a, 32'h0000_0077);

    // write during reset is discarded
    rst = 1'b1; we0 = 1'b1; wen0 = 32'd1 << 3; wdata0 = 32'h5;
    tick();
    rst = 1'b0; we0 = 1'b0; wen0 = '0; raddr0 = 5'd3; raddr1 = 5'd5;
    tick();
    check("rstwr_r3",   rdata0_a, 32'd0);
    check("rstwr_r5",   rdata1_a, 32'd0);
    check("rstwr_wcnt", {16'd0, wcnt0_a}, 32'd0);
    check("rstwr_err",  {31'd0, err0_a}, 32'd0);

    // counter wrap: 65535 writes then one more
    raddr0 = 5'd0; raddr1 = 5'd0;
    for (int i = 0; i < 65535; i++) begin
      we0 = 1'b1; wen0 = 32'd1 << ((i % 31) + 1); wdata0 = i;
      tick();
    end
    check("wcnt_ffff", {16'd0, wcnt0_a}, 32'h0000_FFFF);
    // i=65535: (65535 % 31) + 1 = 1 + 1 = 2
    wen0 = 32'd1 << 2; wdata0 = 32'd65535;
    tick();
    check("wcnt_wrap", {16'd0, wcnt0_a}, 32'd0);
    we0 = 1'b0; wen0 = '0; raddr0 = 5'd2; raddr1 = 5'd31;
    tick();
    // last write to r31 was i=65533 (65533 % 31 = 30)
    check("wrap_r2",  rdata0_a, 32'd65535);
    check("wrap_r31", rdata1_a, 32'd65533);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_32.md
Name: reg_file_32

Overview:
- 32-entry register file; the write port is driven directly by the 1-to-32 demultiplexer stage, whose 32 decoded enables select the target register.
- Two synchronous read ports with optional same-cycle write bypass.
- Register 0 is hardwired to zero.
- Flags malformed (non-one-hot) enable vectors from the decoder stage.

Parameters:
- WIDTH, 32, data width of each register and of the write/read data ports.
- BYPASS, 1, 1 = a read of the register being written this cycle returns the new data; 0 = it returns the old data.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- we0  input  1  global write strobe.
- wen0  input  32  decoded write enables from the demux stage; bit i selects register i.
- wdata0  input  WIDTH  write data.
- raddr0  input  5  read address, port 0.
- raddr1  input  5  read address, port 1.
- rdata0  output  WIDTH  registered read data, port 0.
- rdata1  output  WIDTH  registered read data, port 1.
- err0  output  1  sticky flag: a write was attempted with more than one enable bit set.
- wcnt0  output  16  count of committed writes, wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All 32 registers, rdata0, rdata1, err0 and wcnt0 are cleared to 0.
  - Reset has priority over any write or read in the same cycle; a write presented during reset is discarded.
- Write-valid condition: valid_w = we0 & (wen0 has exactly one bit set).
  - idx is the position of the set bit.
- Committed write (valid_w=1, idx != 0):
  - reg[idx] <= wdata0 at the edge.
  - wcnt0 increments by 1; 16'hFFFF wraps to 0.
- Write to register 0 (valid_w=1, idx == 0): no register changes, wcnt0 does not increment, err0 is not set.
- we0=1, wen0=0: no write, no count, no error.
- we0=1, popcount(wen0) >= 2:
  - No register is written and wcnt0 is unchanged.
  - err0 <= 1 and stays 1 until reset.
- we0=0: wen0 is ignored entirely, including multi-hot values, and err0 is not set.
- Reads have 1-cycle latency. At each edge, for port p in {0,1}:
  - raddrp == 0: rdatap <= 0.
  - Else if BYPASS=1, a committed write hits this cycle, and idx == raddrp: rdatap <= wdata0.
  - Else: rdatap <= reg[raddrp], the value before this edge's write.
- Both ports may read the same address in the same cycle; each receives an identical value.
- Outputs hold their value between edges; no combinational path exists from the inputs to any output.
- Reset de-asserted mid-sequence: the first edge with rst=0 behaves normally from the all-zero state.

Test Plan:
- Reset, then rst=0; read r1..r31 on both ports -> all rdata = 0, err0 = 0, wcnt0 = 0.
- we0=1, wen0=32'h0000_0020, wdata0=32'hDEAD_BEEF; next cycle raddr0=5 -> rdata0 = 32'hDEAD_BEEF one cycle later, wcnt0 = 1.
- Bypass: same cycle we0=1, wen0=1<<7, wdata0=32'h1234_5678, raddr1=7 -> with BYPASS=1, rdata1 = 32'h1234_5678 after that edge; with BYPASS=0, rdata1 = 0.
- we0=1, wen0=32'h1, wdata0=32'hFFFF_FFFF; then raddr0=0 -> rdata0 = 0, wcnt0 unchanged, err0 = 0.
- we0=1, wen0=32'h0000_0006, wdata0=32'hAAAA_AAAA -> r1 and r2 unchanged (still 0), err0 = 1 and stays 1 across later valid writes until rst.
- Write r3=32'h5 with rst=1 in the same cycle -> after reset r3 reads 0 and wcnt0 = 0. Also run 65 536 committed writes -> wcnt0 wraps to 0.
